reg_scoreboard: RTL

REG_SCOREBOARD -- requirements
Module: reg_scoreboard

---
 rtl/reg_scoreboard.sv | 96 +++++++++
 1 files changed

// File: rtl/reg_scoreboard.sv
// Register scoreboard: tracks outstanding writes per architectural register and
// blocks issue on RAW hazards or when a register already has MAX_PEND writes in flight.
module reg_scoreboard #(
  parameter int MAX_PEND = 3
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic        issue_valid,
  input  logic [4:0]  issue_rd,
  input  logic [4:0]  issue_rs,
  input  logic [4:0]  issue_rt,
  input  logic        retire_valid,
  input  logic [4:0]  retire_rd,
  input  logic        flush,
  output logic        stall,
  output logic [31:0] busy_vec,
  output logic [6:0]  pend_total,
  output logic        err
);

  localparam logic [1:0] MaxCnt = 2'(MAX_PEND);

  logic [1:0]  cnt      [32];
  logic [1:0]  cnt_next [32];
  logic [1:0]  eff      [32];
  logic [31:0] issue_oh;
  logic [31:0] retire_oh;
  logic [31:0] nonzero;
  logic [31:0] ret_hit;
  logic [31:0] inc_vec;
  logic [31:0] dec_vec;
  logic [31:0] busy_next;
  logic [6:0]  pend_next;
  logic        accept;
  logic        underflow;

  // Register 0 is masked out of both decodes, so its counter stays at zero.
  always_comb begin
    issue_oh  = (32'd1 << issue_rd) & ~32'd1;
    retire_oh = (32'd1 << retire_rd) & ~32'd1;
    nonzero   = '0;
    for (int n = 0; n < 32; n++) begin
      nonzero[n] = (cnt[n] != 2'd0);
    end
    ret_hit = retire_valid ? (retire_oh & nonzero) : 32'd0;
    for (int n = 0; n < 32; n++) begin
      eff[n] = cnt[n] - {1'b0, ret_hit[n]};
    end
  end

  // Hazard check uses the bypassed counts so a same-cycle retire can unblock issue.
  always_comb begin
    stall = issue_valid &&
            (((issue_rs != 5'd0) && (eff[issue_rs] != 2'd0)) ||
             ((issue_rt != 5'd0) && (eff[issue_rt] != 2'd0)) ||
             ((issue_rd != 5'd0) && (eff[issue_rd] == MaxCnt)));
    accept    = issue_valid && !stall && !flush;
    inc_vec   = accept ? issue_oh : 32'd0;
    dec_vec   = flush ? 32'd0 : ret_hit;
    underflow = retire_valid && !flush && (retire_rd != 5'd0) && (cnt[retire_rd] == 2'd0);
  end

  always_comb begin
    busy_next = '0;
    for (int n = 0; n < 32; n++) begin
      if (flush) begin
        cnt_next[n] = 2'd0;
      end else begin
        cnt_next[n] = cnt[n] + {1'b0, inc_vec[n]} - {1'b0, dec_vec[n]};
      end
      busy_next[n] = (cnt_next[n] != 2'd0);
    end
    if (flush) begin
      pend_next = 7'd0;
    end else begin
      pend_next = pend_total + {6'd0, |inc_vec} - {6'd0, |dec_vec};
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      cnt        <= '{default: 2'd0};
      busy_vec   <= '0;
      pend_total <= '0;
      err        <= 1'b0;
    end else begin
      cnt        <= cnt_next;
      busy_vec   <= busy_next;
      pend_total <= pend_next;
      if (underflow) begin
        err <= 1'b1;
      end
    end
  end

endmodule
